retire_trace_buffer: RTL

Sits directly downstream of the hart's instruction retire interface and consumes one retire record per valid cycle. It captures the architecturally relevant fields into a record FIFO and streams each record out as four 32-bit words over a valid/ready channel to a host or trace sink. It also keeps retired-instruction and dropped-record counters and flags trace completion once the halting instruction has been fully drained.

---
 rtl/retire_trace_buffer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: captures retired-instruction records into a FIFO and
// streams each one out as four 32-bit words over a valid/ready channel.
module retire_trace_buffer #(
  parameter int DEPTH = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_retire_valid,
  input  logic [31:0] i_retire_inst,
  input  logic        i_retire_trap,
  input  logic        i_retire_halt,
  input  logic [31:0] i_retire_pc,
  input  logic [4:0]  i_retire_rd_waddr,
  input  logic [31:0] i_retire_rd_wdata,
  output logic        o_rec_valid,
  input  logic        i_rec_ready,
  output logic [31:0] o_rec_data,
  output logic        o_rec_last,
  output logic [63:0] o_instret,
  output logic [31:0] o_dropped,
  output logic        o_full,
  output logic        o_empty,
  output logic        o_done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    W0 = 2'd0,
    W1 = 2'd1,
    W2 = 2'd2,
    W3 = 2'd3
  } word_e;

  word_e       word_r, word_next_s;
  logic [AW:0] wr_ptr_r, rd_ptr_r;
  logic        halt_seen_r;
  logic        done_r;
  logic [63:0] instret_r;
  logic [31:0] dropped_r;

  logic [31:0] pc_mem_r    [DEPTH];
  logic [31:0] inst_mem_r  [DEPTH];
  logic [31:0] wdata_mem_r [DEPTH];
  logic [7:0]  meta_mem_r  [DEPTH];

  logic          empty_s, full_s, hs_s, pop_s, capture_s, push_s, drop_s;
  logic [AW-1:0] head_s, tail_s;
  logic [31:0]   rec_data_s;
  logic          rec_last_s;

  assign empty_s   = (wr_ptr_r == rd_ptr_r);
  assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign head_s    = rd_ptr_r[AW-1:0];
  assign tail_s    = wr_ptr_r[AW-1:0];
  assign hs_s      = !empty_s && i_rec_ready;
  assign pop_s     = hs_s && (word_r == W3);
  // A full FIFO still accepts a record in the same cycle its head completes.
  assign capture_s = i_retire_valid && !halt_seen_r;
  assign push_s    = capture_s && (!full_s || pop_s);
  assign drop_s    = capture_s && !push_s;

  // Record storage; w2 is stored already masked so the read side is a plain mux.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      pc_mem_r[tail_s]    <= i_retire_pc;
      inst_mem_r[tail_s]  <= i_retire_inst;
      wdata_mem_r[tail_s] <= (i_retire_rd_waddr != 5'd0) ? i_retire_rd_wdata : 32'h0000_0000;
      meta_mem_r[tail_s]  <= {i_retire_trap, i_retire_halt, 1'b0, i_retire_rd_waddr};
    end
  end

  // Pointers, counters and halt/done tracking.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      halt_seen_r <= 1'b0;
      done_r      <= 1'b0;
      instret_r   <= 64'd0;
      dropped_r   <= 32'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (capture_s) begin
        instret_r <= instret_r + 64'd1;
      end
      if (drop_s && (dropped_r != 32'hFFFF_FFFF)) begin
        dropped_r <= dropped_r + 32'd1;
      end
      if (capture_s && i_retire_halt) begin
        halt_seen_r <= 1'b1;
      end
      // Halt record may itself have been dropped; only an empty FIFO matters.
      if (halt_seen_r && empty_s) begin
        done_r <= 1'b1;
      end
    end
  end

  // Word counter state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      word_r <= W0;
    end else begin
      word_r <= word_next_s;
    end
  end

  // Word counter advances only on a handshake.
  always_comb begin
    word_next_s = word_r;
    if (hs_s) begin
      case (word_r)
        W0:      word_next_s = W1;
        W1:      word_next_s = W2;
        W2:      word_next_s = W3;
        W3:      word_next_s = W0;
        default: word_next_s = W0;
      endcase
    end else begin
      word_next_s = word_r;
    end
  end

  // Output word mux from the FIFO head; zero while nothing is buffered.
  always_comb begin
    rec_data_s = 32'h0000_0000;
    rec_last_s = 1'b0;
    if (empty_s) begin
      rec_data_s = 32'h0000_0000;
      rec_last_s = 1'b0;
    end else begin
      case (word_r)
        W0:      rec_data_s = pc_mem_r[head_s];
        W1:      rec_data_s = inst_mem_r[head_s];
        W2:      rec_data_s = wdata_mem_r[head_s];
        W3:      rec_data_s = {24'h00_0000, meta_mem_r[head_s]};
        default: rec_data_s = 32'h0000_0000;
      endcase
      rec_last_s = (word_r == W3);
    end
  end

  assign o_rec_valid = !empty_s;
  assign o_rec_data  = rec_data_s;
  assign o_rec_last  = rec_last_s;
  assign o_instret   = instret_r;
  assign o_dropped   = dropped_r;
  assign o_full      = full_s;
  assign o_empty     = empty_s;
  assign o_done      = done_r;

endmodule
